// File: rtl/vedic_dot_acc_if.sv
// Operand/result handshake bundle for vedic_dot_acc.
// The slave side is the accumulator; the master side is the operand source and result sink.
interface vedic_dot_acc_if #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a;
  logic [31:0]      b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, acc, count, ovf
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, acc, count, ovf
  );
endinterface

// File: rtl/vedic_dot_acc.sv
// Streaming dot-product accumulator over vedic 32x32 products; VEDIC_ACC_SATURATE_EN clamps acc on overflow instead of wrapping.
// Latency: product register then accumulator register, so out_valid follows the last term's transfer by 2 edges; 1 term/cycle.
// Backpressure: in HOLD the result is frozen and in_ready stays low until out_ready; in_ready never depends on in_valid.
module vedic_nxn #(
  parameter int W = 32
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p
);
  if (W == 2) begin : g_base
    logic t, u, c1, hh;
    assign t  = x[1] & y[0];
    assign u  = x[0] & y[1];
    assign c1 = t & u;
    assign hh = x[1] & y[1];
    assign p  = {hh & c1, hh ^ c1, t ^ u, x[0] & y[0]};
  end else begin : g_rec
    localparam int H = W / 2;
    logic [W-1:0] ll, lh, hl, hh;
    vedic_nxn #(.W(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(ll));
    vedic_nxn #(.W(H)) u_lh (.x(x[H-1:0]), .y(y[W-1:H]), .p(lh));
    vedic_nxn #(.W(H)) u_hl (.x(x[W-1:H]), .y(y[H-1:0]), .p(hl));
    vedic_nxn #(.W(H)) u_hh (.x(x[W-1:H]), .y(y[W-1:H]), .p(hh));
    // Cross terms sit H bits up; the exact product always fits in 2W bits.
    assign p = {hh, ll} + {{H{1'b0}}, lh, {H{1'b0}}} + {{H{1'b0}}, hl, {H{1'b0}}};
  end
endmodule

module vedic_32x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  vedic_nxn #(.W(32)) u_core (.x(a), .y(b), .p(p));
endmodule

module vedic_dot_acc #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  vedic_dot_acc_if.slave bus
);
  typedef enum logic {RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [63:0]      prod;
  logic [63:0]      p_reg;
  logic             p_vld;
  logic             p_last;
  logic             first;
  logic [CNT_W-1:0] idx;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             out_vld_q;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W:0]   sum;
  logic             xfer;
  logic             consume;
  logic             last_now;

  vedic_32x32 u_mul (.a(bus.a), .b(bus.b), .p(prod));

  assign bus.in_ready  = (state == RUN) && !(p_vld && p_last);
  assign bus.out_valid = out_vld_q;
  assign bus.acc       = acc_q;
  assign bus.count     = cnt_q;
  assign bus.ovf       = ovf_q;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign consume  = (state == RUN) && p_vld;
  // The 2^CNT_W-th term of a frame closes it even without in_last.
  assign last_now = bus.in_last || (idx == {CNT_W{1'b1}});
  assign p_ext    = ACC_W'(p_reg);
  assign sum      = {1'b0, acc_q} + {1'b0, p_ext};

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (consume && p_last) state_nxt = HOLD;
      HOLD:    if (bus.out_ready)     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg     <= '0;
      p_vld     <= 1'b0;
      p_last    <= 1'b0;
      idx       <= '0;
      first     <= 1'b1;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      if (xfer) begin
        p_reg  <= prod;
        p_vld  <= 1'b1;
        p_last <= last_now;
        idx    <= last_now ? '0 : idx + CNT_W'(1);
      end else if (consume) begin
        p_vld <= 1'b0;
      end

      if (consume) begin
        if (first) begin
          acc_q <= p_ext;
          cnt_q <= '0;
          ovf_q <= 1'b0;
          first <= 1'b0;
        end else begin
`ifdef VEDIC_ACC_SATURATE_EN
          acc_q <= (ovf_q || sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_q <= sum[ACC_W-1:0];
`endif
          cnt_q <= cnt_q + CNT_W'(1);
          ovf_q <= ovf_q | sum[ACC_W];
        end
        if (p_last) out_vld_q <= 1'b1;
      end

      if (state == HOLD && bus.out_ready) begin
        out_vld_q <= 1'b0;
        first     <= 1'b1;
      end
    end
  end
endmodule
